// File: rtl/cnn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_ctrl_pkg
// Purpose  : Shared types and constants for the convolution-engine control path.
// Revision : 1.0
// ============================================================================
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    // Memory read plus multiplier latency; the MAC array wrapper uses the same value.
    localparam int c_PIPE_LAT   = 4;
    localparam int c_OUT_WIDTH  = 8;
    localparam int c_KERNEL     = 5;
    localparam int c_IN_MAPS    = 5;
    localparam int c_OUT_GROUPS = 2;

    // Index width for an extent of n, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_MAP_W = idx_w(c_IN_MAPS);
    localparam int c_KER_W = idx_w(c_KERNEL);
    localparam int c_PIX_W = idx_w(c_OUT_WIDTH);
    localparam int c_GRP_W = idx_w(c_OUT_GROUPS);

endpackage : cnn_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_delay_line
// Purpose  : Shift register for control strobes; every stage is exposed as a tap.
// Revision : 1.0
// ============================================================================
module ctrl_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              din,
    output logic [DEPTH-1:0][WIDTH-1:0]   taps
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
        end else if (clear) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign taps = r_stage;

endmodule : ctrl_delay_line
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sequencer
// Purpose  : Walks groups/rows/cols/maps/kernel taps, one MAC slot per cycle.
// Revision : 1.0
// ============================================================================
module conv_layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int OUT_WIDTH  = c_OUT_WIDTH,
    parameter int KERNEL     = c_KERNEL,
    parameter int IN_MAPS    = c_IN_MAPS,
    parameter int OUT_GROUPS = c_OUT_GROUPS,
    parameter int PIPE_LAT   = c_PIPE_LAT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_rden,
    output logic [idx_w(IN_MAPS)-1:0]       map_sel,
    output logic [idx_w(KERNEL)-1:0]        k_row,
    output logic [idx_w(KERNEL)-1:0]        k_col,
    output logic [idx_w(OUT_WIDTH)-1:0]     o_row,
    output logic [idx_w(OUT_WIDTH)-1:0]     o_col,
    output logic [idx_w(OUT_GROUPS)-1:0]    o_grp,
    output logic                            accum_sload,
    output logic                            result_valid
);

    localparam int c_MW = idx_w(IN_MAPS);
    localparam int c_KW = idx_w(KERNEL);
    localparam int c_PW = idx_w(OUT_WIDTH);
    localparam int c_GW = idx_w(OUT_GROUPS);
    localparam int c_DW = idx_w(PIPE_LAT + 1);

    localparam logic [c_MW-1:0] c_MAP_LAST   = c_MW'(IN_MAPS - 1);
    localparam logic [c_KW-1:0] c_K_LAST     = c_KW'(KERNEL - 1);
    localparam logic [c_PW-1:0] c_PIX_LAST   = c_PW'(OUT_WIDTH - 1);
    localparam logic [c_GW-1:0] c_GRP_LAST   = c_GW'(OUT_GROUPS - 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(PIPE_LAT);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [c_KW-1:0]   r_k_col;
    logic [c_KW-1:0]   r_k_row;
    logic [c_MW-1:0]   r_map_sel;
    logic [c_PW-1:0]   r_o_col;
    logic [c_PW-1:0]   r_o_row;
    logic [c_GW-1:0]   r_o_grp;
    logic [c_DW-1:0]   r_drain_cnt;
    logic              r_done;

    logic w_kc_last, w_kr_last, w_map_last, w_oc_last, w_or_last, w_og_last;
    logic w_slot_first, w_slot_last, w_layer_last;
    logic w_issue, w_advance, w_drain_last;
    logic [PIPE_LAT:0][1:0] w_taps;
    logic w_unused_taps;

    assign w_kc_last    = (r_k_col == c_K_LAST);
    assign w_kr_last    = (r_k_row == c_K_LAST);
    assign w_map_last   = (r_map_sel == c_MAP_LAST);
    assign w_oc_last    = (r_o_col == c_PIX_LAST);
    assign w_or_last    = (r_o_row == c_PIX_LAST);
    assign w_og_last    = (r_o_grp == c_GRP_LAST);
    assign w_slot_first = (r_k_col == '0) && (r_k_row == '0) && (r_map_sel == '0);
    assign w_slot_last  = w_kc_last && w_kr_last && w_map_last;
    assign w_layer_last = w_slot_last && w_oc_last && w_or_last && w_og_last;
    assign w_issue      = (r_state == ST_ISSUE);
    assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);

    // A stalled pixel boundary keeps its last-slot indices until HOLD releases.
    assign w_advance = (w_issue && (!w_slot_last || out_ready || w_layer_last))
                    || ((r_state == ST_HOLD) && out_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_layer_last)                   w_next_state = ST_DRAIN;
                else if (w_slot_last && !out_ready) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) w_next_state = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (w_drain_last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (abort) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_k_col   <= '0;
            r_k_row   <= '0;
            r_map_sel <= '0;
            r_o_col   <= '0;
            r_o_row   <= '0;
            r_o_grp   <= '0;
        end else if (abort) begin
            r_k_col   <= '0;
            r_k_row   <= '0;
            r_map_sel <= '0;
            r_o_col   <= '0;
            r_o_row   <= '0;
            r_o_grp   <= '0;
        end else if (w_advance) begin
            r_k_col <= w_kc_last ? '0 : r_k_col + 1'b1;
            if (w_kc_last)
                r_k_row <= w_kr_last ? '0 : r_k_row + 1'b1;
            if (w_kc_last && w_kr_last)
                r_map_sel <= w_map_last ? '0 : r_map_sel + 1'b1;
            if (w_slot_last)
                r_o_col <= w_oc_last ? '0 : r_o_col + 1'b1;
            if (w_slot_last && w_oc_last)
                r_o_row <= w_or_last ? '0 : r_o_row + 1'b1;
            if (w_slot_last && w_oc_last && w_or_last)
                r_o_grp <= w_og_last ? '0 : r_o_grp + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            if (abort || (r_state != ST_DRAIN)) r_drain_cnt <= '0;
            else                                r_drain_cnt <= r_drain_cnt + 1'b1;
            r_done <= !abort && (r_state == ST_DRAIN) && w_drain_last;
        end
    end

    // Bit 0 carries first-slot, bit 1 last-slot; one extra stage aligns the result strobe.
    ctrl_delay_line #(
        .DEPTH (PIPE_LAT + 1),
        .WIDTH (2)
    ) u_delay_line (
        .clock (clock),
        .reset (reset),
        .clear (abort),
        .din   ({w_issue && w_slot_last, w_issue && w_slot_first}),
        .taps  (w_taps)
    );

    assign w_unused_taps = ^w_taps;

    always_comb begin
        busy         = (r_state != ST_IDLE);
        done         = r_done;
        mem_rden     = w_issue;
        map_sel      = r_map_sel;
        k_row        = r_k_row;
        k_col        = r_k_col;
        o_row        = r_o_row;
        o_col        = r_o_col;
        o_grp        = r_o_grp;
        accum_sload  = w_taps[PIPE_LAT-1][0];
        result_valid = w_taps[PIPE_LAT][1];
    end

endmodule : conv_layer_sequencer
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_sequencer
// Purpose  : Directed checks of the layer sequencer on a 2x2x2x2 layer.
// Revision : 1.0
// ============================================================================
module tb_conv_layer_sequencer;
    import cnn_ctrl_pkg::*;

    localparam int OW = 2, KS = 2, IM = 2, OG = 1, PL = 4;
    localparam int MAXC = 128;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic busy, done, mem_rden, accum_sload, result_valid;
    logic [idx_w(IM)-1:0] map_sel;
    logic [idx_w(KS)-1:0] k_row, k_col;
    logic [idx_w(OW)-1:0] o_row, o_col;
    logic [idx_w(OG)-1:0] o_grp;

    conv_layer_sequencer #(
        .OUT_WIDTH (OW), .KERNEL (KS), .IN_MAPS (IM), .OUT_GROUPS (OG), .PIPE_LAT (PL)
    ) dut (
        .clock (clock), .reset (reset), .start (start), .abort (abort),
        .out_ready (out_ready), .busy (busy), .done (done), .mem_rden (mem_rden),
        .map_sel (map_sel), .k_row (k_row), .k_col (k_col), .o_row (o_row),
        .o_col (o_col), .o_grp (o_grp), .accum_sload (accum_sload),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [MAXC-1:0] lg_busy, lg_done, lg_rden, lg_sload, lg_rv;
    int lg_map[MAXC], lg_kr[MAXC], lg_kc[MAXC], lg_oc[MAXC], lg_or[MAXC];

    typedef struct {
        int c;
        int busy, done, rden, sload, rv;
        int map, kr, kc, oc, orw;
    } vec_t;
    vec_t nom_tab[15];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_opt(input string name, input int act, input int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    task automatic chk_mask(input string name, input logic [MAXC-1:0] act,
                            input logic [MAXC-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [MAXC-1:0] m_range(input int a, input int b);
        logic [MAXC-1:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAXC-1:0] m_every(input int first, input int step, input int cnt);
        logic [MAXC-1:0] m = '0;
        for (int i = 0; i < cnt; i++) m[first + i*step] = 1'b1;
        return m;
    endfunction

    function automatic logic start_at(input int sc, input int c);
        case (sc)
            2:       return (c == 0) || (c == 15);
            3:       return (c == 0) || (c == 30);
            4:       return (c <= 40);
            default: return (c == 0);
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input int c);
        lg_busy[c] = busy;   lg_done[c] = done;   lg_rden[c] = mem_rden;
        lg_sload[c] = accum_sload;  lg_rv[c] = result_valid;
        lg_map[c] = int'(map_sel);  lg_kr[c] = int'(k_row);  lg_kc[c] = int'(k_col);
        lg_oc[c] = int'(o_col);     lg_or[c] = int'(o_row);
    endtask

    task automatic apply(input int sc, input int c);
        start     = start_at(sc, c);
        abort     = (sc == 3) && (c == 20);
        out_ready = !((sc == 1) && (c >= 8) && (c <= 10));
    endtask

    // Cycle c is the cycle after edge c-1; inputs set in cycle c are sampled at edge c.
    task automatic run(input int sc, input int ncyc);
        do_reset();
        lg_busy = '0; lg_done = '0; lg_rden = '0; lg_sload = '0; lg_rv = '0;
        sample(0);
        apply(sc, 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock);
            #1;
            sample(c);
            apply(sc, c);
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_masks(input string tag, input logic [MAXC-1:0] rden_m,
                               input logic [MAXC-1:0] busy_m, input logic [MAXC-1:0] sload_m,
                               input logic [MAXC-1:0] rv_m, input logic [MAXC-1:0] done_m);
        chk_mask({tag, " mem_rden"}, lg_rden, rden_m);
        chk_mask({tag, " busy"}, lg_busy, busy_m);
        chk_mask({tag, " accum_sload"}, lg_sload, sload_m);
        chk_mask({tag, " result_valid"}, lg_rv, rv_m);
        chk_mask({tag, " done"}, lg_done, done_m);
    endtask

    initial begin
        int map_pat[8];
        logic any_out;
        vec_t v;
        map_pat = '{0, 0, 0, 0, 1, 1, 1, 1};

        //            c   busy done rden sld rv  map kr kc oc or
        nom_tab[0]  = '{ 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0};
        nom_tab[1]  = '{ 1, 1, 0, 1, 0, 0,  0,  0,  0,  0,  0};
        nom_tab[2]  = '{ 2, 1, 0, 1, 0, 0,  0,  0,  1,  0,  0};
        nom_tab[3]  = '{ 4, 1, 0, 1, 0, 0,  0,  1,  1,  0,  0};
        nom_tab[4]  = '{ 5, 1, 0, 1, 1, 0,  1,  0,  0,  0,  0};
        nom_tab[5]  = '{ 8, 1, 0, 1, 0, 0,  1,  1,  1,  0,  0};
        nom_tab[6]  = '{ 9, 1, 0, 1, 0, 0,  0,  0,  0,  1,  0};
        nom_tab[7]  = '{13, 1, 0, 1, 1, 1,  1,  0,  0,  1,  0};
        nom_tab[8]  = '{17, 1, 0, 1, 0, 0,  0,  0,  0,  0,  1};
        nom_tab[9]  = '{26, 1, 0, 1, 0, 0,  0,  0,  1,  1,  1};
        nom_tab[10] = '{32, 1, 0, 1, 0, 0,  1,  1,  1,  1,  1};
        nom_tab[11] = '{33, 1, 0, 0, 0, 0, -1, -1, -1, -1, -1};
        nom_tab[12] = '{37, 1, 0, 0, 0, 1, -1, -1, -1, -1, -1};
        nom_tab[13] = '{38, 0, 1, 0, 0, 0, -1, -1, -1, -1, -1};
        nom_tab[14] = '{39, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1};

        // Nominal run
        run(0, 45);
        for (int i = 0; i < 15; i++) begin
            v = nom_tab[i];
            chk_opt($sformatf("nom c%0d busy", v.c),  int'(lg_busy[v.c]),  v.busy);
            chk_opt($sformatf("nom c%0d done", v.c),  int'(lg_done[v.c]),  v.done);
            chk_opt($sformatf("nom c%0d rden", v.c),  int'(lg_rden[v.c]),  v.rden);
            chk_opt($sformatf("nom c%0d sload", v.c), int'(lg_sload[v.c]), v.sload);
            chk_opt($sformatf("nom c%0d rv", v.c),    int'(lg_rv[v.c]),    v.rv);
            chk_opt($sformatf("nom c%0d map", v.c),   lg_map[v.c], v.map);
            chk_opt($sformatf("nom c%0d krow", v.c),  lg_kr[v.c],  v.kr);
            chk_opt($sformatf("nom c%0d kcol", v.c),  lg_kc[v.c],  v.kc);
            chk_opt($sformatf("nom c%0d ocol", v.c),  lg_oc[v.c],  v.oc);
            chk_opt($sformatf("nom c%0d orow", v.c),  lg_or[v.c],  v.orw);
        end
        for (int c = 1; c <= 32; c++)
            chk($sformatf("nom map_sel c%0d", c), lg_map[c], map_pat[(c-1) % 8]);
        check_masks("nom", m_range(1, 32), m_range(1, 37), m_every(5, 8, 4),
                    m_every(13, 8, 4), m_every(38, 1, 1));

        // Back-pressure: out_ready low in cycles 8..10
        run(1, 50);
        for (int c = 9; c <= 11; c++) begin
            chk($sformatf("hold c%0d o_col", c), lg_oc[c], 0);
            chk($sformatf("hold c%0d k_col", c), lg_kc[c], 1);
        end
        chk("hold release o_col", lg_oc[12], 1);
        chk("hold release k_col", lg_kc[12], 0);
        check_masks("bp", m_range(1, 8) | m_range(12, 35), m_range(1, 40),
                    m_every(5, 1, 1) | m_every(16, 8, 3),
                    m_every(13, 1, 1) | m_every(24, 8, 3), m_every(41, 1, 1));

        // start while busy is ignored
        run(2, 60);
        check_masks("start_busy", m_range(1, 32), m_range(1, 37), m_every(5, 8, 4),
                    m_every(13, 8, 4), m_every(38, 1, 1));

        // abort at cycle 20, restart at cycle 30
        run(3, 75);
        chk("abort o_row before", lg_or[20], 1);
        chk("abort o_row after", lg_or[21], 0);
        chk("abort k_col after", lg_kc[21], 0);
        check_masks("abort", m_range(1, 20) | m_range(31, 62),
                    m_range(1, 20) | m_range(31, 67),
                    m_every(5, 8, 2) | m_every(35, 8, 4),
                    m_every(13, 1, 1) | m_every(43, 8, 4), m_every(68, 1, 1));

        // Back-to-back layers with start held through done
        run(4, 85);
        check_masks("b2b", m_range(1, 32) | m_range(39, 70),
                    m_range(1, 37) | m_range(39, 75),
                    m_every(5, 8, 4) | m_every(43, 8, 4),
                    m_every(13, 8, 4) | m_every(51, 8, 4), m_every(38, 38, 2));

        // Asynchronous reset mid-issue
        do_reset();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #3;
        chk("areset pre busy", int'(busy), 1);
        chk("areset pre o_col", int'(o_col), 1);
        reset = 1'b1;
        #1;
        chk("areset busy", int'(busy), 0);
        chk("areset mem_rden", int'(mem_rden), 0);
        chk("areset o_col", int'(o_col), 0);
        chk("areset k_col", int'(k_col), 0);
        chk("areset other outputs",
            int'({done, accum_sload, result_valid, map_sel, k_row, o_row, o_grp}), 0);
        #2 reset = 1'b0;
        any_out = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            any_out = any_out | busy | done | mem_rden | accum_sload | result_valid
                    | (|o_col) | (|k_col) | (|map_sel);
        end
        chk("areset quiet until start", int'(any_out), 0);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("restart first issue", int'(mem_rden), 1);
        chk("restart busy", int'(busy), 1);
        repeat (3) @(posedge clock);
        #1;
        chk("restart sload c4", int'(accum_sload), 0);
        @(posedge clock);
        #1;
        chk("restart sload c5", int'(accum_sload), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_conv_layer_sequencer
`default_nettype wire
